// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator and DAC output stage. Sync and blank are delayed
// to line up with pixel data that arrives PIPE_DELAY cycles after hcount/vcount.
module vga_timing_ctrl #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int COLOR_DEPTH = 8,
    parameter int PIPE_DELAY  = 1
) (
    input  logic                       vga_clk,
    input  logic                       reset_n,
    output logic [9:0]                 hcount,
    output logic [9:0]                 vcount,
    output logic                       frame_start,
    input  logic [3*COLOR_DEPTH-1:0]   rgb_in,
    output logic [COLOR_DEPTH-1:0]     vga_r,
    output logic [COLOR_DEPTH-1:0]     vga_g,
    output logic [COLOR_DEPTH-1:0]     vga_b,
    output logic                       vga_hs,
    output logic                       vga_vs,
    output logic                       vga_blank_n,
    output logic                       vga_sync_n
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    // Stage word layout: {hs, vs, active}; inactive value is hs=1, vs=1, active=0.
    localparam logic [2:0] STAGE_IDLE = 3'b110;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $fatal(1, "vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
        $fatal(1, "vga_timing_ctrl: PIPE_DELAY must be in 0..4");
    end

    logic [9:0]                 hcount_reg;
    logic [9:0]                 hcount_next;
    logic [9:0]                 vcount_reg;
    logic [9:0]                 vcount_next;
    logic [2:0]                 raw_bits;
    logic [2:0]                 dly_reg [0:PIPE_DELAY];
    logic [3*COLOR_DEPTH-1:0]   rgb_reg;
    logic                       act_dly;

    always_comb begin
        hcount_next = hcount_reg + 10'd1;
        vcount_next = vcount_reg;
        if (hcount_reg == 10'(H_TOTAL - 1)) begin
            hcount_next = '0;
            if (vcount_reg == 10'(V_TOTAL - 1)) begin
                vcount_next = '0;
            end else begin
                vcount_next = vcount_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
        end
    end

    // Compare in 11 bits so an end bound of exactly 1024 does not wrap to 0.
    always_comb begin
        raw_bits    = STAGE_IDLE;
        raw_bits[2] = !(({1'b0, hcount_reg} >= 11'(HS_START)) &&
                        ({1'b0, hcount_reg} <  11'(HS_END)));
        raw_bits[1] = !(({1'b0, vcount_reg} >= 11'(VS_START)) &&
                        ({1'b0, vcount_reg} <  11'(VS_END)));
        raw_bits[0] = ({1'b0, hcount_reg} < 11'(H_VISIBLE)) &&
                      ({1'b0, vcount_reg} < 11'(V_VISIBLE));
    end

    for (genvar gi = 0; gi <= PIPE_DELAY; gi++) begin : g_dly
        if (gi == 0) begin : g_first
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    dly_reg[gi] <= STAGE_IDLE;
                end else begin
                    dly_reg[gi] <= raw_bits;
                end
            end
        end else begin : g_rest
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    dly_reg[gi] <= STAGE_IDLE;
                end else begin
                    dly_reg[gi] <= dly_reg[gi-1];
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_reg <= '0;
        end else begin
            rgb_reg <= rgb_in;
        end
    end

    // reset_n gate keeps the pulse low while the counters are held at zero in reset.
    assign frame_start = reset_n && (hcount_reg == 10'd0) && (vcount_reg == 10'd0);

    assign hcount      = hcount_reg;
    assign vcount      = vcount_reg;
    assign act_dly     = dly_reg[PIPE_DELAY][0];
    assign vga_hs      = dly_reg[PIPE_DELAY][2];
    assign vga_vs      = dly_reg[PIPE_DELAY][1];
    assign vga_blank_n = act_dly;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = act_dly ? rgb_reg[3*COLOR_DEPTH-1:2*COLOR_DEPTH] : '0;
    assign vga_g       = act_dly ? rgb_reg[2*COLOR_DEPTH-1:COLOR_DEPTH]   : '0;
    assign vga_b       = act_dly ? rgb_reg[COLOR_DEPTH-1:0]               : '0;

endmodule
